// File: rtl/pc_sequencer.sv
// Program-counter sequencer: turns decoder branch requests into PC jump controls, owns the return stack,
// stretches boot reset, and parks the PC on itself in HALT/FAULT. Outputs are combinational from state + requests.
module pc_sequencer #(
  parameter int                         INSTR_ADDR_SIZE = 8,
  parameter int                         STACK_DEPTH     = 4,
  parameter int                         RESET_CYCLES    = 2,
  parameter logic [INSTR_ADDR_SIZE-1:0] FAULT_VECTOR    = 8'hF0
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic [INSTR_ADDR_SIZE-1:0]         instruction_address,
  input  logic                               call_req,
  input  logic                               ret_req,
  input  logic                               jump_req,
  input  logic                               halt_req,
  input  logic                               resume,
  input  logic [INSTR_ADDR_SIZE-1:0]         target_addr,
  output logic [4:0]                         jump_code,
  output logic [INSTR_ADDR_SIZE-1:0]         jump_address,
  output logic [INSTR_ADDR_SIZE-1:0]         return_address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               halted,
  output logic                               fault,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = $clog2(RESET_CYCLES + 1);

  localparam logic [4:0] JC_RESET   = 5'd0;
  localparam logic [4:0] JC_JUMP    = 5'd1;
  localparam logic [4:0] JC_RET     = 5'd2;
  localparam logic [4:0] JC_DEFAULT = 5'd3;

  localparam logic [INSTR_ADDR_SIZE-1:0] ADDR_ONE  = INSTR_ADDR_SIZE'(1);
  localparam logic [DW-1:0]              DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0]              DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [CW-1:0]              BOOT_LAST = CW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t                      state;
  logic [CW-1:0]               boot_cnt;
  logic [INSTR_ADDR_SIZE-1:0]  stack_mem [STACK_DEPTH];

  logic          stack_full;
  logic          stack_empty;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;

  logic do_push;
  logic do_pop;
  logic go_halt;
  logic go_fault;
  logic set_ovf;
  logic set_unf;

  assign stack_full  = (stack_depth == DEPTH_MAX);
  assign stack_empty = (stack_depth == '0);
  assign top_idx     = IW'(stack_depth - DEPTH_ONE);
  assign push_idx    = IW'(stack_depth);

  assign return_address = stack_empty ? '0 : stack_mem[top_idx];
  assign halted         = RESET_N && (state == ST_HALT);
  assign fault          = RESET_N && (state == ST_FAULT);

  // Request arbitration: halt > ret > call > jump; only the winner has side effects.
  always_comb begin
    jump_code    = JC_DEFAULT;
    jump_address = target_addr;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    go_halt      = 1'b0;
    go_fault     = 1'b0;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    if (!RESET_N) begin
      jump_code = JC_RESET;
    end else begin
      case (state)
        ST_BOOT: jump_code = JC_RESET;
        ST_RUN: begin
          if (halt_req) begin
            jump_code    = JC_JUMP;
            jump_address = instruction_address;
            go_halt      = 1'b1;
          end else if (ret_req) begin
            if (stack_empty) begin
              jump_code    = JC_JUMP;
              jump_address = FAULT_VECTOR;
              go_fault     = 1'b1;
              set_unf      = 1'b1;
            end else begin
              jump_code = JC_RET;
              do_pop    = 1'b1;
            end
          end else if (call_req) begin
            jump_code = JC_JUMP;
            if (stack_full) begin
              jump_address = FAULT_VECTOR;
              go_fault     = 1'b1;
              set_ovf      = 1'b1;
            end else begin
              jump_address = target_addr;
              do_push      = 1'b1;
            end
          end else if (jump_req) begin
            jump_code    = JC_JUMP;
            jump_address = target_addr;
          end
        end
        ST_HALT, ST_FAULT: begin
          jump_code    = JC_JUMP;
          jump_address = instruction_address;
        end
        default: jump_code = JC_RESET;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= ST_BOOT;
      boot_cnt    <= '0;
      stack_depth <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) state <= ST_RUN;
          else                       boot_cnt <= boot_cnt + CW'(1);
        end
        ST_RUN: begin
          if (go_halt)  state     <= ST_HALT;
          if (go_fault) state     <= ST_FAULT;
          if (set_ovf)  overflow  <= 1'b1;
          if (set_unf)  underflow <= 1'b1;
          if (do_push)  stack_depth <= stack_depth + DEPTH_ONE;
          if (do_pop)   stack_depth <= stack_depth - DEPTH_ONE;
        end
        ST_HALT: begin
          if (resume) state <= ST_RUN;
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_BOOT;
      endcase
    end
  end

  // Entries above the depth pointer are don't-care, so the array needs no reset.
  always_ff @(posedge CLK) begin
    if (do_push) stack_mem[push_idx] <= instruction_address + ADDR_ONE;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC model closing the loop.
module tb_pc_sequencer;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] instruction_address;
  logic       call_req, ret_req, jump_req, halt_req, resume;
  logic [7:0] target_addr;
  logic [4:0] jump_code;
  logic [7:0] jump_address;
  logic [7:0] return_address;
  logic [2:0] stack_depth;
  logic       halted, fault, overflow, underflow;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] pc;

  pc_sequencer #(
    .INSTR_ADDR_SIZE(8),
    .STACK_DEPTH(4),
    .RESET_CYCLES(2),
    .FAULT_VECTOR(8'hF0)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .instruction_address(instruction_address),
    .call_req(call_req),
    .ret_req(ret_req),
    .jump_req(jump_req),
    .halt_req(halt_req),
    .resume(resume),
    .target_addr(target_addr),
    .jump_code(jump_code),
    .jump_address(jump_address),
    .return_address(return_address),
    .stack_depth(stack_depth),
    .halted(halted),
    .fault(fault),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Program counter as the sequencer sees it.
  always @(posedge CLK) begin
    case (jump_code)
      5'd0:    pc <= 8'h00;
      5'd1:    pc <= jump_address;
      5'd2:    pc <= return_address;
      5'd3:    pc <= pc + 8'h01;
      default: pc <= 8'hxx;
    endcase
  end
  assign instruction_address = pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic idle();
    call_req = 0; ret_req = 0; jump_req = 0; halt_req = 0; resume = 0;
  endtask

  task automatic do_jump(input logic [7:0] t);
    idle(); jump_req = 1; target_addr = t;
    mid(); chk("jump_code_jump", jump_code, 5'd1);
    adv(); idle();
  endtask

  initial begin
    RESET_N = 0; target_addr = 8'h00; idle();

    // Boot: three low cycles, then RESET held two more
    for (int i = 0; i < 3; i++) begin
      mid(); chk("rst_jump_code", jump_code, 5'd0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_fault", fault, 1'b0);
      adv();
    end
    chk("rst_depth", stack_depth, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_unf", underflow, 1'b0);
    chk("rst_retaddr", return_address, 8'h00);
    RESET_N = 1;
    for (int i = 0; i < 2; i++) begin
      mid(); chk("boot_jump_code", jump_code, 5'd0);
      call_req = 1; target_addr = 8'h55;  // ignored in BOOT
      adv(); idle();
    end
    chk("boot_pc0", pc, 8'h00);
    chk("boot_depth", stack_depth, 3'd0);
    mid(); chk("run_default", jump_code, 5'd3);
    adv(); chk("pc1", pc, 8'h01);
    adv(); chk("pc2", pc, 8'h02);

    // Call / ret
    do_jump(8'h10); chk("pc_10", pc, 8'h10);
    call_req = 1; target_addr = 8'h40;
    mid(); chk("call_code", jump_code, 5'd1); chk("call_addr", jump_address, 8'h40);
    adv(); idle();
    chk("call_pc", pc, 8'h40); chk("call_depth", stack_depth, 3'd1);
    chk("call_ret_addr", return_address, 8'h11);
    adv(); adv(); chk("pc_42", pc, 8'h42);
    ret_req = 1;
    mid(); chk("ret_code", jump_code, 5'd2); chk("ret_addr_out", return_address, 8'h11);
    adv(); idle();
    chk("ret_pc", pc, 8'h11); chk("ret_depth", stack_depth, 3'd0);
    chk("ret_empty_addr", return_address, 8'h00);

    // Priority: ret beats call and jump
    do_jump(8'h20);
    call_req = 1; target_addr = 8'h50; adv(); idle();
    chk("prio_setup_top", return_address, 8'h21);
    call_req = 1; ret_req = 1; jump_req = 1; target_addr = 8'h77;
    mid(); chk("prio_code", jump_code, 5'd2);
    adv(); idle();
    chk("prio_pc", pc, 8'h21); chk("prio_depth", stack_depth, 3'd0);

    // Halt / resume
    do_jump(8'h30);
    halt_req = 1; call_req = 1; target_addr = 8'h66;
    mid(); chk("halt_code", jump_code, 5'd1); chk("halt_addr", jump_address, 8'h30);
    adv(); idle();
    chk("halt_depth", stack_depth, 3'd0);
    for (int i = 0; i < 5; i++) begin
      jump_req = (i == 2); target_addr = 8'h99;
      mid(); chk("halted_flag", halted, 1'b1);
      adv(); chk("halt_pc", pc, 8'h30);
    end
    idle(); resume = 1;
    mid(); chk("resume_hold_halted", halted, 1'b1);
    adv(); idle(); chk("resume_pc_held", pc, 8'h30);
    mid(); chk("resume_halted_clr", halted, 1'b0); chk("resume_code", jump_code, 5'd3);
    adv(); chk("resume_pc_31", pc, 8'h31);

    // Address wrap on push
    do_jump(8'hFF);
    call_req = 1; target_addr = 8'h60; adv(); idle();
    chk("wrap_ret_addr", return_address, 8'h00); chk("wrap_depth", stack_depth, 3'd1);
    chk("wrap_pc", pc, 8'h60);

    // Fill the stack, then overflow
    call_req = 1; target_addr = 8'h70; adv();
    target_addr = 8'h80; adv();
    target_addr = 8'h90; adv(); idle();
    chk("full_depth", stack_depth, 3'd4); chk("full_top", return_address, 8'h81);
    call_req = 1; target_addr = 8'hA0;
    mid(); chk("ovf_code", jump_code, 5'd1); chk("ovf_vec", jump_address, 8'hF0);
    adv(); idle();
    chk("ovf_flag", overflow, 1'b1); chk("ovf_fault", fault, 1'b1);
    chk("ovf_pc", pc, 8'hF0); chk("ovf_depth", stack_depth, 3'd4);
    for (int i = 0; i < 10; i++) begin
      ret_req = 1;
      adv(); chk("fault_hold_pc", pc, 8'hF0);
    end
    idle();
    chk("fault_depth_kept", stack_depth, 3'd4); chk("fault_no_unf", underflow, 1'b0);

    // Reset out of fault, then underflow
    RESET_N = 0;
    mid(); chk("rst2_fault_low", fault, 1'b0);
    adv(); RESET_N = 1;
    chk("rst2_ovf", overflow, 1'b0); chk("rst2_depth", stack_depth, 3'd0);
    mid(); chk("rst2_boot_a", jump_code, 5'd0); adv();
    mid(); chk("rst2_boot_b", jump_code, 5'd0); adv();
    do_jump(8'h05);
    ret_req = 1;
    mid(); chk("unf_code", jump_code, 5'd1); chk("unf_vec", jump_address, 8'hF0);
    adv(); idle();
    chk("unf_flag", underflow, 1'b1); chk("unf_fault", fault, 1'b1); chk("unf_pc", pc, 8'hF0);
    adv(); adv(); chk("unf_hold_pc", pc, 8'hF0);
    RESET_N = 0; adv(); RESET_N = 1;
    chk("rst3_unf", underflow, 1'b0); chk("rst3_fault", fault, 1'b0);
    mid(); chk("rst3_boot_a", jump_code, 5'd0); adv();
    mid(); chk("rst3_boot_b", jump_code, 5'd0); adv();
    mid(); chk("rst3_run", jump_code, 5'd3); adv();
    chk("rst3_pc1", pc, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block for the program counter: decodes per-cycle branch requests from the decoder into the PC's 5-bit jump_code, jump_address and return_address inputs.
- Owns the hardware return-address stack for CALL/RET.
- Stretches the PC reset after boot.
- Implements halt and fault states by repeatedly jumping the PC to its own address.
- Sits between the instruction decoder and the PC; all outputs feed the PC directly.

Parameters:
- INSTR_ADDR_SIZE, 8, width of all instruction addresses.
- STACK_DEPTH, 4, return-stack entries; must be at least 1.
- RESET_CYCLES, 2, number of cycles the RESET code is held after RESET_N deasserts; must be at least 1.
- FAULT_VECTOR, 8'hF0, address the PC jumps to on stack fault; INSTR_ADDR_SIZE bits wide.

Ports:
- CLK, in, 1, clock, rising edge.
- RESET_N, in, 1, synchronous reset, active-low.
- instruction_address, in, INSTR_ADDR_SIZE, current PC value.
- call_req, in, 1, CALL to target_addr this cycle.
- ret_req, in, 1, RET this cycle.
- jump_req, in, 1, JUMP to target_addr this cycle.
- halt_req, in, 1, enter HALT.
- resume, in, 1, leave HALT.
- target_addr, in, INSTR_ADDR_SIZE, branch target.
- jump_code, out, 5, to PC: RESET=0, JUMP=1, RET=2, DEFAULT=3 (increment).
- jump_address, out, INSTR_ADDR_SIZE, to PC.
- return_address, out, INSTR_ADDR_SIZE, to PC; equals the top of stack, or 0 when the stack is empty.
- stack_depth, out, $clog2(STACK_DEPTH+1), number of valid entries.
- halted, out, 1, high in HALT.
- fault, out, 1, high in FAULT.
- overflow, out, 1, sticky; set by CALL on a full stack.
- underflow, out, 1, sticky; set by RET on an empty stack.

Behaviour:
- Output timing: outputs are combinational from registered state plus current-cycle requests. A request in cycle n changes the PC at the end of cycle n.
- Reset (RESET_N=0 at an edge): state=BOOT, boot counter=0, stack_depth=0, overflow=underflow=0. While RESET_N=0: jump_code=RESET, halted=fault=0.
- BOOT:
  - jump_code=RESET for exactly RESET_CYCLES cycles after RESET_N rises, then RUN.
  - All requests are ignored.
- RUN, request priority: halt_req > ret_req > call_req > jump_req. Only the winner acts; losers are dropped with no side effects.
  - No request: jump_code=DEFAULT.
  - jump_req: jump_code=JUMP, jump_address=target_addr.
  - call_req, depth<STACK_DEPTH: push (instruction_address+1) mod 2^INSTR_ADDR_SIZE; jump_code=JUMP, jump_address=target_addr; depth+1 at the edge.
  - call_req, depth==STACK_DEPTH: no push; set overflow; go to FAULT. This cycle emits JUMP to FAULT_VECTOR.
  - ret_req, depth>0: jump_code=RET, return_address=top; pop (depth-1) at the edge.
  - ret_req, depth==0: set underflow; go to FAULT. This cycle emits JUMP to FAULT_VECTOR.
  - halt_req: jump_code=JUMP, jump_address=instruction_address; state becomes HALT next cycle. The stack is unchanged.
- HALT:
  - jump_code=JUMP, jump_address=instruction_address every cycle, so the PC is frozen. halted=1.
  - resume=1: this cycle still holds; RUN from the next cycle.
  - Branch requests are ignored.
- FAULT:
  - jump_code=JUMP, jump_address=instruction_address, so the PC is frozen at FAULT_VECTOR. fault=1.
  - Exit is only via reset.
- Stack:
  - LIFO register array. The top entry is index depth-1.
  - Entries above depth are don't-care.
  - return_address is always driven from the top, regardless of jump_code.
- Reset mid-operation: RESET_N=0 in any state takes effect at the next edge. The stack empties and sticky flags clear.

Test Plan:
- Boot: RESET_N low 3 cycles then high, RESET_CYCLES=2 -> jump_code=0 for the 3 low cycles plus 2 more, then 3; PC counts 0,1,2…
- Call/ret: at PC=0x10, call_req with target_addr=0x40 -> next PC=0x40, depth=1, return_address=0x11. At PC=0x42, ret_req -> jump_code=2, next PC=0x11, depth=0.
- Nesting and overflow (STACK_DEPTH=4): 4 calls succeed, depth=4. A 5th call -> overflow=1, fault=1, PC=0xF0 and stays there for 10 cycles; depth stays 4.
- Underflow: ret_req with depth=0 at PC=0x05 -> underflow=1, PC=0xF0, held. RESET_N low for one edge -> flags clear, BOOT re-runs.
- Priority: call_req, ret_req and jump_req together with depth=1, top=0x21 -> RET wins, PC=0x21, depth=0, nothing pushed.
- Halt/resume and wrap: halt_req at PC=0x30 -> PC held at 0x30 for 5 cycles, halted=1; resume -> PC 0x31 the cycle after RUN resumes. A call at PC=0xFF pushes 0x00.
